// File: rtl/pio_multi_channel.sv
// Parametrised Avalon-MM parallel I/O: output register with atomic set/clear,
// synchronised inputs with edge capture, and a maskable level/edge interrupt.
module pio_multi_channel #(
    parameter int               WIDTH       = 2,
    parameter int               MODE        = 0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               IRQ_TYPE    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] pio_in,
    output logic [WIDTH-1:0] pio_out,
    output logic [WIDTH-1:0] pio_oe,
    output logic             irq
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0] out_reg, out_next;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] cap_reg, cap_next;
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] wdata;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             irq_src;
    logic [31:0]      rd_val;
    logic             wr_data, wr_dir, wr_mask, wr_cap, wr_set, wr_clr;
    logic             unused_wdata;

    function automatic logic [ARM_W-1:0] sat_inc(input logic [ARM_W-1:0] v);
        return (v == ARM_W'(ARM_MAX)) ? v : v + ARM_W'(1);
    endfunction

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    assign wdata        = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;
    assign sync_in      = sync_p[SYNC_STAGES-1];
    assign armed        = (arm_cnt == ARM_W'(ARM_MAX));
    assign pio_out      = out_reg;

    assign wr_data = avs_write && (avs_address == 3'd0);
    assign wr_dir  = avs_write && (avs_address == 3'd1);
    assign wr_mask = avs_write && (avs_address == 3'd2);
    assign wr_cap  = avs_write && (avs_address == 3'd3);
    assign wr_set  = avs_write && (avs_address == 3'd4);
    assign wr_clr  = avs_write && (avs_address == 3'd5);

    always_comb begin
        if (MODE == 0)      pio_oe = '1;
        else if (MODE == 1) pio_oe = '0;
        else                pio_oe = dir_reg;
    end

    always_comb begin
        if (EDGE_TYPE == 0)      edge_det = sync_in & ~prev_in;
        else if (EDGE_TYPE == 1) edge_det = ~sync_in & prev_in;
        else                     edge_det = sync_in ^ prev_in;
    end

    always_comb begin
        out_next = out_reg;
        if (wr_data && (MODE != 1)) out_next = wdata;
        if (wr_set)                 out_next = out_reg | wdata;
        if (wr_clr)                 out_next = out_reg & ~wdata;
    end

    // A fresh edge outranks a same-cycle write-1-to-clear.
    always_comb begin
        cap_next = cap_reg;
        if (wr_cap) cap_next = cap_reg & ~wdata;
        if (armed)  cap_next = cap_next | edge_det;
    end

    assign irq_src = (IRQ_TYPE == 1) ? |(cap_reg & mask_reg) : |(sync_in & mask_reg);

    always_comb begin
        rd_val = '0;
        case (avs_address)
            3'd0:    rd_val = (MODE == 0) ? zext(out_reg) : zext(sync_in);
            3'd1:    rd_val = zext(pio_oe);
            3'd2:    rd_val = zext(mask_reg);
            3'd3:    rd_val = zext(cap_reg);
            default: rd_val = '0;
        endcase
    end

    // Stage boundary: register file, synchroniser, capture and bus outputs
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            out_reg      <= RESET_VALUE;
            dir_reg      <= '0;
            mask_reg     <= '0;
            cap_reg      <= '0;
            prev_in      <= '0;
            arm_cnt      <= '0;
            avs_readdata <= '0;
            irq          <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
        end else begin
            out_reg <= out_next;
            if (wr_dir && (MODE == 2)) dir_reg <= wdata;
            if (wr_mask)               mask_reg <= wdata;
            cap_reg   <= cap_next;
            sync_p[0] <= pio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            prev_in <= sync_in;
            arm_cnt <= sat_inc(arm_cnt);
            if (avs_read) avs_readdata <= rd_val;
            irq <= irq_src;
        end
    end

endmodule

// File: tb/tb_pio_multi_channel.sv
// Bench for pio_multi_channel: four configurations sharing clock and reset,
// table-driven register checks, directed edge/irq sequences and a random run.
module tb_pio_multi_channel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  addr [4];
    logic        rd_s [4];
    logic        wr_s [4];
    logic [31:0] wdat [4];

    logic [31:0] rdat0, rdat1, rdat2, rdat3;
    logic        irq0, irq1, irq2, irq3;
    logic [1:0]  pin0, pout0, oe0;
    logic [7:0]  pin1, pout1, oe1;
    logic [3:0]  pin2, pout2, oe2;
    logic [1:0]  pin3, pout3, oe3;

    int n_checks = 0;
    int n_fail   = 0;

    pio_multi_channel #(.WIDTH(2), .MODE(0), .RESET_VALUE(2'b10)) d0 (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr[0]), .avs_read(rd_s[0]),
        .avs_write(wr_s[0]), .avs_writedata(wdat[0]), .avs_readdata(rdat0),
        .pio_in(pin0), .pio_out(pout0), .pio_oe(oe0), .irq(irq0));

    pio_multi_channel #(.WIDTH(8), .MODE(0)) d1 (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr[1]), .avs_read(rd_s[1]),
        .avs_write(wr_s[1]), .avs_writedata(wdat[1]), .avs_readdata(rdat1),
        .pio_in(pin1), .pio_out(pout1), .pio_oe(oe1), .irq(irq1));

    pio_multi_channel #(.WIDTH(4), .MODE(1), .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(2)) d2 (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr[2]), .avs_read(rd_s[2]),
        .avs_write(wr_s[2]), .avs_writedata(wdat[2]), .avs_readdata(rdat2),
        .pio_in(pin2), .pio_out(pout2), .pio_oe(oe2), .irq(irq2));

    pio_multi_channel #(.WIDTH(2), .MODE(2), .EDGE_TYPE(2), .IRQ_TYPE(0), .SYNC_STAGES(2)) d3 (
        .clk_clk(clk), .reset_reset(rst), .avs_address(addr[3]), .avs_read(rd_s[3]),
        .avs_write(wr_s[3]), .avs_writedata(wdat[3]), .avs_readdata(rdat3),
        .pio_in(pin3), .pio_out(pout3), .pio_oe(oe3), .irq(irq3));

    typedef struct {
        bit          is_rd;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdv(input int d);
        case (d)
            0:       return rdat0;
            1:       return rdat1;
            2:       return rdat2;
            default: return rdat3;
        endcase
    endfunction

    task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v);
        addr[d] = a;
        wdat[d] = v;
        wr_s[d] = 1'b1;
        step();
        wr_s[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [2:0] a, output logic [31:0] v);
        addr[d] = a;
        rd_s[d] = 1'b1;
        step();
        rd_s[d] = 1'b0;
        v = rdv(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [3:0]  hist [$];
        logic [3:0]  m_cap, m_mask, m_cap_n, rise, clr;
        logic        m_irq, do_rd, do_wr;
        logic [2:0]  op_a;
        logic [31:0] op_d, exp_rd;

        for (int i = 0; i < 4; i++) begin
            addr[i] = '0; rd_s[i] = 1'b0; wr_s[i] = 1'b0; wdat[i] = '0;
        end
        pin0 = '0; pin1 = '0; pin2 = '0; pin3 = 2'b11;

        tbl[0]  = '{1'b0, 3'd0, 32'h0000_000F, 32'h0, 8'h0F};
        tbl[1]  = '{1'b0, 3'd4, 32'h0000_00C0, 32'h0, 8'hCF};
        tbl[2]  = '{1'b0, 3'd5, 32'h0000_0003, 32'h0, 8'hCC};
        tbl[3]  = '{1'b1, 3'd0, 32'h0,         32'h0000_00CC, 8'hCC};
        tbl[4]  = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0, 8'hFF};
        tbl[5]  = '{1'b1, 3'd0, 32'h0,         32'h0000_00FF, 8'hFF};
        tbl[6]  = '{1'b1, 3'd1, 32'h0,         32'h0000_00FF, 8'hFF};
        tbl[7]  = '{1'b0, 3'd1, 32'h0000_0000, 32'h0, 8'hFF};
        tbl[8]  = '{1'b1, 3'd1, 32'h0,         32'h0000_00FF, 8'hFF};
        tbl[9]  = '{1'b1, 3'd4, 32'h0,         32'h0, 8'hFF};
        tbl[10] = '{1'b1, 3'd5, 32'h0,         32'h0, 8'hFF};
        tbl[11] = '{1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0, 8'hFF};
        tbl[12] = '{1'b1, 3'd2, 32'h0,         32'h0000_00FF, 8'hFF};
        tbl[13] = '{1'b0, 3'd7, 32'h0000_0005, 32'h0, 8'hFF};
        tbl[14] = '{1'b1, 3'd7, 32'h0,         32'h0, 8'hFF};
        tbl[15] = '{1'b0, 3'd5, 32'h0000_00F0, 32'h0, 8'h0F};
        tbl[16] = '{1'b1, 3'd0, 32'h0,         32'h0000_000F, 8'h0F};
        tbl[17] = '{1'b0, 3'd4, 32'h0000_0130, 32'h0, 8'h3F};
        tbl[18] = '{1'b1, 3'd0, 32'h0,         32'h0000_003F, 8'h3F};

        // Reset state
        step(); step();
        check("rst_rdata0", rdat0, 32'h0);
        check("rst_pio_out0", 32'(pout0), 32'h2);
        check("rst_pio_oe0", 32'(oe0), 32'h3);
        check("rst_irq0", 32'(irq0), 32'h0);
        check("rst_pio_out1", 32'(pout1), 32'h0);
        check("rst_pio_oe1", 32'(oe1), 32'hFF);
        check("rst_pio_oe2", 32'(oe2), 32'h0);
        rst = 1'b0;

        rd(0, 3'd0, v);
        check("d0_read_data", v, 32'h2);

        // Pins held high through reset release never capture
        for (int i = 0; i < 10; i++) step();
        rd(3, 3'd3, v);
        check("d3_cap_static_pins", v, 32'h0);

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].is_rd) begin
                rd(1, tbl[i].a, v);
                check($sformatf("tbl%0d_rd", i), v, tbl[i].exp_rd);
            end else begin
                wr(1, tbl[i].a, tbl[i].d);
            end
            check($sformatf("tbl%0d_out", i), 32'(pout1), 32'(tbl[i].exp_out));
        end

        // Same-cycle read and write of DATA returns the pre-write value
        addr[1] = 3'd0; wdat[1] = 32'h55; rd_s[1] = 1'b1; wr_s[1] = 1'b1;
        step();
        rd_s[1] = 1'b0; wr_s[1] = 1'b0;
        check("rw_same_cycle_rd", rdat1, 32'h3F);
        check("rw_same_cycle_out", 32'(pout1), 32'h55);

        // MODE 2 direction and any-edge capture
        wr(3, 3'd1, 32'h1);
        wr(3, 3'd0, 32'h3);
        check("d3_oe", 32'(oe3), 32'h1);
        check("d3_out", 32'(pout3), 32'h3);
        rd(3, 3'd1, v);
        check("d3_dir_rd", v, 32'h1);
        rd(3, 3'd0, v);
        check("d3_data_rd", v, 32'h3);
        pin3 = 2'b01;
        for (int i = 0; i < 6; i++) step();
        pin3 = 2'b11;
        for (int i = 0; i < 6; i++) step();
        rd(3, 3'd3, v);
        check("d3_any_edge_cap", v, 32'h2);
        wr(3, 3'd3, 32'h2);
        rd(3, 3'd3, v);
        check("d3_cap_cleared", v, 32'h0);

        // Level interrupt
        wr(3, 3'd2, 32'h2);
        pin3 = 2'b01;
        for (int i = 0; i < 6; i++) step();
        check("d3_irq_low", 32'(irq3), 32'h0);
        pin3 = 2'b11;
        step(); step();
        check("d3_irq_t2", 32'(irq3), 32'h0);
        step();
        check("d3_irq_t3", 32'(irq3), 32'h1);

        // Edge capture and edge interrupt on d2
        wr(2, 3'd2, 32'h1);
        for (int i = 0; i < 3; i++) step();
        pin2 = 4'h1;
        step(); step();
        rd(2, 3'd3, v);
        check("d2_cap_t3_pre", v, 32'h0);
        check("d2_irq_t3", 32'(irq2), 32'h0);
        rd(2, 3'd3, v);
        check("d2_cap_t3", v, 32'h1);
        check("d2_irq_t4", 32'(irq2), 32'h1);
        wr(2, 3'd3, 32'h1);
        check("d2_irq_clr_edge", 32'(irq2), 32'h1);
        step();
        check("d2_irq_after_clr", 32'(irq2), 32'h0);

        // Edge arriving in the same cycle as its clear keeps the bit set
        pin2 = 4'h0;
        for (int i = 0; i < 5; i++) step();
        pin2 = 4'h1;
        for (int i = 0; i < 5; i++) step();
        check("d2_irq_rearmed", 32'(irq2), 32'h1);
        pin2 = 4'h0;
        for (int i = 0; i < 5; i++) step();
        pin2 = 4'h1;
        step(); step();
        wr(2, 3'd3, 32'h1);
        check("d2_race_irq0", 32'(irq2), 32'h1);
        step();
        check("d2_race_irq1", 32'(irq2), 32'h1);
        rd(2, 3'd3, v);
        check("d2_race_cap", v, 32'h1);
        check("d2_race_irq2", 32'(irq2), 32'h1);

        // Randomised run against a delay-based reference
        wr(2, 3'd2, 32'hF);
        wr(2, 3'd3, 32'hF);
        step(); step();
        check("d2_rand_start_irq", 32'(irq2), 32'h0);
        m_cap = 4'h0; m_mask = 4'hF; m_irq = 1'b0;
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(pin2);
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) == 0) pin2 = 4'($urandom);
            do_rd = 1'b0; do_wr = 1'b0; op_a = 3'd0; op_d = $urandom;
            case ($urandom_range(0, 5))
                0, 1: begin do_rd = 1'b1; op_a = 3'($urandom_range(0, 7)); end
                2:    begin do_wr = 1'b1; op_a = 3'd2; end
                3:    begin do_wr = 1'b1; op_a = 3'd3; end
                default: ;
            endcase
            addr[2] = op_a; wdat[2] = op_d; rd_s[2] = do_rd; wr_s[2] = do_wr;
            hist.push_back(pin2);

            // Input seen by the capture logic lags the pins by SYNC_STAGES+1 cycles
            rise = hist[$-2] & ~hist[$-3];
            clr  = (do_wr && op_a == 3'd3) ? op_d[3:0] : 4'h0;
            case (op_a)
                3'd0:    exp_rd = {28'h0, hist[$-2]};
                3'd2:    exp_rd = {28'h0, m_mask};
                3'd3:    exp_rd = {28'h0, m_cap};
                default: exp_rd = 32'h0;
            endcase
            m_irq   = |(m_cap & m_mask);
            m_cap_n = rise | (m_cap & ~clr);
            m_cap   = m_cap_n;
            if (do_wr && op_a == 3'd2) m_mask = op_d[3:0];
            void'(hist.pop_front());

            step();
            rd_s[2] = 1'b0; wr_s[2] = 1'b0;
            if (do_rd) check($sformatf("rand%0d_rd", c), rdat2, exp_rd);
            check($sformatf("rand%0d_irq", c), 32'(irq2), 32'(m_irq));
        end

        // Reset asserted in the middle of a read
        rd(3, 3'd2, v);
        check("d3_mask_rd", v, 32'h2);
        addr[3] = 3'd0; rd_s[3] = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrd_rdata3", rdat3, 32'h0);
        check("midrd_irq3", 32'(irq3), 32'h0);
        check("midrd_pio_out1", 32'(pout1), 32'h0);
        check("midrd_pio_oe3", 32'(oe3), 32'h0);
        check("midrd_pio_out0", 32'(pout0), 32'h2);
        rd_s[3] = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_multi_channel.md
# pio_multi_channel

Parametrised Avalon-MM parallel I/O peripheral for the Nios II system, the next generation of the fixed 2-bit output PIO. It supports configurable width, output/input/bidirectional mode, synchronised inputs with edge capture, atomic set/clear of outputs, and a maskable interrupt. It sits on the system interconnect as a slave and drives board pins through `pio_out` and `pio_oe`; tristate buffers live at the top level.

## Interface
- WIDTH, 2, channel count, 1..32
- MODE, 0, 0 = output only, 1 = input only, 2 = bidirectional
- EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any
- IRQ_TYPE, 0, 0 = level (masked live input), 1 = edge (masked capture register)
- RESET_VALUE, 0, reset value of the output register (WIDTH bits)
- SYNC_STAGES, 2, input synchroniser depth, 2..4

- clk_clk  in  1  system clock; all logic on the rising edge
- reset_reset  in  1  asynchronous, active-high reset
- avs_address  in  3  word register index
- avs_read  in  1  read strobe; fixed read latency of 1, no waitrequest
- avs_write  in  1  write strobe; completes in the same cycle
- avs_writedata  in  32  write data
- avs_readdata  out  32  registered read data
- pio_in  in  WIDTH  asynchronous pin inputs
- pio_out  out  WIDTH  output register
- pio_oe  out  WIDTH  per-bit output enable
- irq  out  1  registered interrupt request

## Operation
- Register map, word addresses:
  - 0: DATA
    - Read: synchronised input in MODE 1/2; the output register in MODE 0.
    - Write: loads the output register (ignored in MODE 1).
  - 1: DIRECTION. 1 = output. Read/write only in MODE 2; otherwise writes are ignored and reads return the fixed `pio_oe`.
  - 2: IRQ_MASK, read/write.
  - 3: EDGE_CAPTURE. Read returns captured bits; write-1-to-clear.
  - 4: OUTSET. Write ORs the data into the output register; reads return 0.
  - 5: OUTCLEAR. Write clears the bits set in the data; reads return 0.
  - 6, 7: reserved. Reads return 0 and writes are ignored.
- Bits at or above WIDTH always read 0 and are ignored on write.
- `pio_oe`: all ones in MODE 0; all zeros in MODE 1; the DIRECTION register in MODE 2.
- Input path:
  - A SYNC_STAGES-deep flop chain per bit feeds `sync_in`.
  - A previous-value register `prev_in` is updated every cycle.
- Edge detection per bit, from `sync_in` and `prev_in`:
  - Rising edge: `sync_in & ~prev_in`.
  - Falling edge: `~sync_in & prev_in`.
  - Any edge: XOR of the two.
- Arming counter:
  - After reset deassertion, edge detection is suppressed for SYNC_STAGES+1 cycles.
  - As a result, pins that are static at reset release never produce a capture.
  - Counts 0..SYNC_STAGES+1, then saturates.
- EDGE_CAPTURE bit update: set if an edge is detected; else cleared if written with 1; else held. When a detect and a clear hit the same bit in the same cycle, the set wins.
- Interrupt:
  - IRQ_TYPE 0: `irq` is the OR of (`sync_in & mask`).
  - IRQ_TYPE 1: `irq` is the OR of (capture & mask).
  - `irq` is registered.
- Read and write to the same register in one cycle: the read returns the pre-write value.

## Timing
- Reset values:
  - Output register = RESET_VALUE; DIRECTION = 0; IRQ_MASK = 0; EDGE_CAPTURE = 0.
  - Synchroniser and `prev_in` = 0; arming counter = 0.
  - `avs_readdata` = 0; `irq` = 0.
  - `pio_out` = RESET_VALUE.
- Reset asserted mid-operation clears all state immediately (asynchronous); no transaction completes.
- Write to DATA, OUTSET, OUTCLEAR or DIRECTION: `pio_out`/`pio_oe` update on the next rising edge.
- Read: `avs_readdata` is valid in the cycle after `avs_read`, and holds until the next read.
- Pin change to DATA visibility: SYNC_STAGES cycles.
- Pin change to EDGE_CAPTURE bit set: SYNC_STAGES+1 cycles.
- `irq` follows one cycle after its source.
- Clearing a capture bit drops an edge-type `irq` one cycle after the write.

## Test plan
- Reset with RESET_VALUE=2'b10, MODE 0, then read address 0 → `avs_readdata`=0x2, `pio_out`=2'b10, `pio_oe`=2'b11, `irq`=0.
- WIDTH=8, MODE 0: write DATA 0x0F, OUTSET 0xC0, OUTCLEAR 0x03 → `pio_out`=0xCC; DATA read 0x0000_00CC; write 0xFFFF_FFFF to DATA → read 0x0000_00FF.
- MODE 1, EDGE_TYPE 0, SYNC_STAGES 2, IRQ_TYPE 1, mask 0x1:
  - Stimulus: raise `pio_in[0]` at cycle t.
  - Capture bit 0 set at t+3 and `irq`=1 at t+4.
  - Write 0x1 to EDGE_CAPTURE → `irq`=0 the cycle after.
- Same-cycle race: a new edge on bit 0 coincides with a write-1 clear of EDGE_CAPTURE → bit stays 1 and `irq` stays 1.
- `pio_in`=all ones through reset release → EDGE_CAPTURE reads 0 after 10 cycles; later falling then rising edge on bit 1 with EDGE_TYPE 2 → bit 1 set.
- MODE 2: write DIRECTION 0x1, DATA 0x3 → `pio_oe`=2'b01 and `pio_out`=2'b11; level IRQ with mask 0x2 and `pio_in[1]`=1 → `irq`=1 after 3 cycles; assert reset mid-read → `avs_readdata`=0 and `irq`=0 immediately.
